// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: FSM encoding and lane-count width helpers.
package writeback_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } wb_state_e;

  // Width able to hold a lane count 0..num_lanes.
  function automatic int lane_cnt_width(input int num_lanes);
    return $clog2(num_lanes) + 1;
  endfunction

  // Width of a lane index; never zero, even for a single lane.
  function automatic int lane_idx_width(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

endpackage

// File: rtl/writeback_arbiter_priority_select.sv
// Fixed-priority encoder: index of the lowest set bit plus a valid flag.
module priority_select
  import writeback_arbiter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int IDX_WIDTH = lane_idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     vec,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 valid
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_WIDTH'(i);
        valid = 1'b1;
      end else begin
        idx   = idx;
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Collects per-lane allocator results for one positioning round and serialises
// them into the output memory, lowest pending lane first, one write per cycle.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_ALLOCATORS = 4,
  parameter int DATA_WIDTH     = 18,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     clear,
  input  logic                                     round_start,
  input  logic [lane_cnt_width(NUM_ALLOCATORS)-1:0] round_lanes,
  input  logic [ADDR_WIDTH-1:0]                    output_memory_offset,
  input  logic [NUM_ALLOCATORS-1:0]                alloc_done,
  input  logic [NUM_ALLOCATORS*DATA_WIDTH-1:0]     alloc_data,
  output logic [NUM_ALLOCATORS-1:0]                alloc_ack,
  output logic [ADDR_WIDTH-1:0]                    out_mem_addr,
  output logic [DATA_WIDTH-1:0]                    out_mem_data,
  output logic                                     out_mem_en,
  output logic                                     round_done,
  output logic                                     busy,
  output logic                                     overrun
);

  localparam int N  = NUM_ALLOCATORS;
  localparam int LW = lane_cnt_width(N);
  localparam int IW = lane_idx_width(N);

  wb_state_e             state_r, state_next_s;
  logic [LW-1:0]         lanes_r, lanes_clamped_s;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [N-1:0]          captured_r, written_r, ack_r;
  logic [N-1:0]          active_mask_s, capture_s, cand_s, issue_s;
  logic [DATA_WIDTH-1:0] data_r [N];
  logic [IW-1:0]         sel_idx_s;
  logic                  sel_valid_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  collect_s, start_s, finish_s, all_written_s;
  logic                  wr_en_r, round_done_r, overrun_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [DATA_WIDTH-1:0] wr_data_r;

  // Round size sanitising: zero means one lane, oversize saturates.
  always_comb begin
    if (round_lanes == LW'(0)) begin
      lanes_clamped_s = LW'(1);
    end else if (int'(round_lanes) > N) begin
      lanes_clamped_s = LW'(N);
    end else begin
      lanes_clamped_s = round_lanes;
    end
  end

  // Lane bookkeeping: which lanes take part, which capture now, which write now.
  always_comb begin
    collect_s     = (state_r == ST_COLLECT);
    start_s       = (state_r == ST_IDLE) && round_start;
    for (int i = 0; i < N; i++) begin
      active_mask_s[i] = (i < int'(lanes_r));
    end
    all_written_s = ((written_r & active_mask_s) == active_mask_s);
    finish_s      = collect_s && all_written_s;
    capture_s     = alloc_done & active_mask_s & ~captured_r & {N{collect_s && !finish_s}};
    // A lane captured on this edge may be written out in the very next cycle.
    cand_s        = (captured_r | capture_s) & ~written_r & {N{collect_s}};
    for (int i = 0; i < N; i++) begin
      issue_s[i] = sel_valid_s && (int'(sel_idx_s) == i);
    end
    if (capture_s[sel_idx_s]) begin
      sel_data_s = alloc_data[int'(sel_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      sel_data_s = data_r[sel_idx_s];
    end
  end

  priority_select #(
    .WIDTH     (N),
    .IDX_WIDTH (IW)
  ) u_priority_select (
    .vec   (cand_s),
    .idx   (sel_idx_s),
    .valid (sel_valid_s)
  );

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    if (clear) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    state_next_s = round_start   ? ST_COLLECT : ST_IDLE;
        ST_COLLECT: state_next_s = all_written_s ? ST_IDLE    : ST_COLLECT;
        default:    state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Round control, flags and the registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lanes_r      <= LW'(1);
      base_r       <= '0;
      captured_r   <= '0;
      written_r    <= '0;
      ack_r        <= '0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= '0;
      wr_data_r    <= '0;
      round_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (clear) begin
      base_r       <= '0;
      captured_r   <= '0;
      written_r    <= '0;
      ack_r        <= '0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= '0;
      wr_data_r    <= '0;
      round_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      ack_r        <= capture_s;
      round_done_r <= finish_s;
      if (start_s) begin
        lanes_r    <= lanes_clamped_s;
        captured_r <= '0;
        written_r  <= '0;
      end else begin
        captured_r <= captured_r | capture_s;
        written_r  <= written_r | issue_s;
      end
      if (finish_s) begin
        base_r <= base_r + ADDR_WIDTH'(lanes_r);
      end
      if (round_start && collect_s) begin
        overrun_r <= 1'b1;
      end
      wr_en_r <= sel_valid_s;
      if (sel_valid_s) begin
        wr_addr_r <= output_memory_offset + base_r + ADDR_WIDTH'(sel_idx_s);
        wr_data_r <= sel_data_s;
      end else begin
        wr_addr_r <= '0;
        wr_data_r <= '0;
      end
    end
  end

  // Per-lane result holding registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) data_r[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) data_r[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (capture_s[i]) data_r[i] <= alloc_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A restart kills any write scheduled for the cycle in which it is asserted.
  assign out_mem_en   = wr_en_r & ~clear;
  assign out_mem_addr = clear ? '0 : wr_addr_r;
  assign out_mem_data = clear ? '0 : wr_data_r;
  assign alloc_ack    = ack_r;
  assign round_done   = round_done_r;
  assign busy         = collect_s;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and randomized checks of writeback_arbiter against a round-level reference model.
module tb_writeback_arbiter;

  localparam int N  = 4;
  localparam int DW = 18;
  localparam int AW = 16;
  localparam int LW = $clog2(N) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              round_start;
  logic [LW-1:0]     round_lanes;
  logic [AW-1:0]     offset;
  logic [N-1:0]      done;
  logic [N*DW-1:0]   data;
  logic [N-1:0]      alloc_ack;
  logic [AW-1:0]     out_mem_addr;
  logic [DW-1:0]     out_mem_data;
  logic              out_mem_en, round_done, busy, overrun;

  writeback_arbiter #(.NUM_ALLOCATORS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .round_start(round_start),
    .round_lanes(round_lanes), .output_memory_offset(offset),
    .alloc_done(done), .alloc_data(data), .alloc_ack(alloc_ack),
    .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data), .out_mem_en(out_mem_en),
    .round_done(round_done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a round is a set of lanes, each captured once and written once.
  bit            m_busy, m_over;
  int            m_lanes;
  logic [AW-1:0] m_base;
  bit            m_cap [N];
  bit            m_wr  [N];
  logic [DW-1:0] m_data [N];
  logic          e_en, e_rd;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [N-1:0]  e_ack;

  logic [AW-1:0] wr_q[$];
  int            ack_cnt [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_over = 0; m_lanes = 1; m_base = '0;
    for (int i = 0; i < N; i++) begin m_cap[i] = 0; m_wr[i] = 0; end
    e_en = 0; e_rd = 0; e_addr = '0; e_data = '0; e_ack = '0;
  endtask

  task automatic model_edge();
    bit all_wr, found;
    e_en = 0; e_rd = 0; e_addr = '0; e_data = '0; e_ack = '0;
    if (clear) begin
      m_reset();
    end else if (!m_busy) begin
      if (round_start) begin
        m_lanes = int'(round_lanes);
        if (m_lanes == 0) m_lanes = 1;
        if (m_lanes > N) m_lanes = N;
        for (int i = 0; i < N; i++) begin m_cap[i] = 0; m_wr[i] = 0; end
        m_busy = 1;
      end
    end else begin
      if (round_start) m_over = 1;
      all_wr = 1;
      for (int i = 0; i < m_lanes; i++) if (!m_wr[i]) all_wr = 0;
      if (all_wr) begin
        m_busy = 0;
        e_rd   = 1;
        m_base = AW'(int'(m_base) + m_lanes);
      end else begin
        for (int i = 0; i < m_lanes; i++) begin
          if (done[i] && !m_cap[i]) begin
            m_cap[i]  = 1;
            m_data[i] = data[i*DW +: DW];
            e_ack[i]  = 1'b1;
          end
        end
        found = 0;
        for (int i = 0; i < m_lanes; i++) begin
          if (!found && m_cap[i] && !m_wr[i]) begin
            found   = 1;
            m_wr[i] = 1;
            e_en    = 1;
            e_addr  = AW'(int'(offset) + int'(m_base) + i);
            e_data  = m_data[i];
          end
        end
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, " en"},   out_mem_en,   e_en);
    check({tag, " addr"}, out_mem_addr, e_addr);
    check({tag, " data"}, out_mem_data, e_data);
    check({tag, " ack"},  alloc_ack,    e_ack);
    check({tag, " rdone"}, round_done,  e_rd);
    check({tag, " busy"}, busy,         m_busy);
    check({tag, " ovr"},  overrun,      m_over);
    if (out_mem_en === 1'b1) wr_q.push_back(out_mem_addr);
    for (int i = 0; i < N; i++) if (alloc_ack[i] === 1'b1) ack_cnt[i]++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " en"},    out_mem_en,   1'b0);
    check({tag, " addr"},  out_mem_addr, 16'h0000);
    check({tag, " data"},  out_mem_data, 18'h00000);
    check({tag, " ack"},   alloc_ack,    4'h0);
    check({tag, " rdone"}, round_done,   1'b0);
    check({tag, " busy"},  busy,         1'b0);
    check({tag, " ovr"},   overrun,      1'b0);
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic clear_log();
    wr_q.delete();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
  endtask

  task automatic start_round(input string tag, input int lanes);
    round_lanes = LW'(lanes);
    round_start = 1'b1;
    step(tag);
    round_start = 1'b0;
  endtask

  initial begin
    int n1;
    rst = 1'b0; clear = 1'b0; round_start = 1'b0; round_lanes = '0;
    offset = '0; done = '0; data = '0;
    m_reset();
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // Four lanes done together: four back-to-back writes from the offset.
    offset = 16'h0100;
    start_round("r034 start", 4);
    clear_log();
    rand_data(); done = 4'hF;
    step("r034 cap");
    done = 4'h0;
    repeat (5) step("r034 run");
    check("r034 nwr", wr_q.size(), 4);
    for (int i = 0; i < 4; i++) check("r034 addr", wr_q[i], 16'h0100 + 16'(i));

    // Out-of-order completion over three lanes; lane 3 is outside the round.
    start_round("r035 start", 3);
    clear_log();
    rand_data(); done = 4'b1100; step("r035 l2");
    done = 4'b1000; repeat (2) step("r035 gap");
    rand_data(); done = 4'b1001; step("r035 l0");
    done = 4'b1000; repeat (2) step("r035 gap");
    rand_data(); done = 4'b1010; step("r035 l1");
    done = 4'b1000; repeat (3) step("r035 tail");
    done = 4'h0;
    check("r035 nwr", wr_q.size(), 3);
    check("r035 a0", wr_q[0], 16'h0106);
    check("r035 a1", wr_q[1], 16'h0104);
    check("r035 a2", wr_q[2], 16'h0105);
    check("r035 ack3", ack_cnt[3], 0);

    // A done level held for several cycles is taken only once.
    start_round("r039 start", 2);
    clear_log();
    rand_data(); done = 4'b0010;
    repeat (5) step("r039 hold");
    done = 4'b0001; step("r039 l0");
    done = 4'h0; repeat (2) step("r039 tail");
    n1 = 0;
    foreach (wr_q[i]) if (wr_q[i] == 16'h0108) n1++;
    check("r039 ack1", ack_cnt[1], 1);
    check("r039 wr1", n1, 1);

    // round_start during a round only flags overrun; clear wipes state.
    start_round("r037 start", 2);
    round_start = 1'b1; rand_data(); done = 4'b0011;
    step("r037 dup");
    round_start = 1'b0; done = 4'h0;
    repeat (3) step("r037 run");
    check("r037 ovr", overrun, 1'b1);
    clear = 1'b1; step("r037 clr");
    clear = 1'b0;
    check("r037 ovr0", overrun, 1'b0);
    check("r037 idle", busy, 1'b0);
    offset = 16'h0200;
    start_round("r037 nxt", 1);
    clear_log();
    rand_data(); done = 4'b0001; step("r037 w");
    done = 4'h0; repeat (2) step("r037 tail");
    check("r037 base0", wr_q[0], 16'h0200);

    // Address arithmetic wraps at the top of the address space.
    clear = 1'b1; step("r036 clr");
    clear = 1'b0; offset = 16'hFFFE;
    start_round("r036 start", 4);
    clear_log();
    rand_data(); done = 4'hF; step("r036 cap");
    done = 4'h0; repeat (5) step("r036 run");
    check("r036 a0", wr_q[0], 16'hFFFE);
    check("r036 a1", wr_q[1], 16'hFFFF);
    check("r036 a2", wr_q[2], 16'h0000);
    check("r036 a3", wr_q[3], 16'h0001);
    offset = 16'h0000;
    start_round("r036 nxt", 1);
    clear_log();
    rand_data(); done = 4'b0001; step("r036 w");
    done = 4'h0; repeat (2) step("r036 tail");
    check("r036 base", wr_q[0], 16'h0004);

    // Reset in the middle of a round.
    start_round("r038 start", 4);
    rand_data(); done = 4'b0011; step("r038 cap");
    done = 4'h0;
    #2 rst = 1'b0;
    #1 check_all_zero("r038 rst");
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    clear_log();
    done = 4'b0011;
    repeat (6) step("r038 post");
    done = 4'h0;
    check("r038 nwr", wr_q.size(), 0);

    // Randomized traffic, including clamped lane counts, overruns and restarts.
    for (int c = 0; c < 400; c++) begin
      round_start = ($urandom_range(0, 7) == 0);
      round_lanes = LW'($urandom_range(0, 7));
      clear       = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) offset = AW'($urandom);
      done = N'($urandom);
      rand_data();
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter NUM_ALLOCATORS, default 4, number of allocator result lanes (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 18, result word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, output memory address width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port clear  input  1  synchronous restart for a new (image, filter) pair.
REQ-007 SHALL have port round_start  input  1  one-cycle pulse opening a positioning round.
REQ-008 SHALL have port round_lanes  input  $clog2(NUM_ALLOCATORS)+1  active lanes this round (1..NUM_ALLOCATORS), sampled on round_start.
REQ-009 SHALL have port output_memory_offset  input  ADDR_WIDTH  base address of the output region.
REQ-010 SHALL have port alloc_done  input  NUM_ALLOCATORS  per-lane result-ready level.
REQ-011 SHALL have port alloc_data  input  NUM_ALLOCATORS*DATA_WIDTH  packed results; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port alloc_ack  output  NUM_ALLOCATORS  one-cycle capture acknowledge per lane.
REQ-013 SHALL have port out_mem_addr  output  ADDR_WIDTH  physical write address.
REQ-014 SHALL have port out_mem_data  output  DATA_WIDTH  write data.
REQ-015 SHALL have port out_mem_en  output  1  write strobe.
REQ-016 SHALL have port round_done  output  1  one-cycle pulse: all active lanes written.
REQ-017 SHALL have port busy  output  1  high in COLLECT.
REQ-018 SHALL have port overrun  output  1  sticky: round_start received while busy.

Function
REQ-019 SHALL implement states IDLE and COLLECT; IDLE->COLLECT on round_start; COLLECT->IDLE on the cycle after the last active lane is written.
REQ-020 SHALL, on round_start in IDLE, latch round_lanes (0 treated as 1; values >NUM_ALLOCATORS clamped) and clear all per-lane captured/written flags.
REQ-021 SHALL capture lane i (data register + captured flag) on the first clock edge in COLLECT where alloc_done[i]=1, i<lanes, and lane i not yet captured; alloc_ack[i] is high the following cycle only.
REQ-022 SHALL ignore alloc_done on inactive lanes, on already-captured lanes, and in IDLE (no ack).
REQ-023 SHALL each cycle select the lowest-index lane captured but not written and drive out_mem_en=1, out_mem_data=its data, out_mem_addr=output_memory_offset+base+lane (modulo 2^ADDR_WIDTH); at most one write per cycle.
REQ-024 SHALL give minimum latency of one cycle: alloc_done sampled at edge t -> out_mem_en high during cycle after t.
REQ-025 SHALL keep out_mem_en=0 and out_mem_addr/out_mem_data at 0 when no write is pending.
REQ-026 SHALL pulse round_done in the cycle after the final write, together with base <= base+lanes (wrapping modulo 2^ADDR_WIDTH).
REQ-027 SHALL ignore round_start in COLLECT apart from setting overrun.
REQ-028 SHALL on clear (any state) return to IDLE, zero base, drop captured/pending data, clear overrun, suppress out_mem_en that cycle; clear has priority over round_start.

Reset
REQ-029 SHALL on rst low asynchronously force: state IDLE, base 0, all flags 0, alloc_ack 0, out_mem_en 0, out_mem_addr 0, out_mem_data 0, round_done 0, busy 0, overrun 0.
REQ-030 SHALL apply reset mid-round with no write completing after reset assertion.

Structure
REQ-031 SHALL place state encoding and the lane-count width function in the shared accel package.
REQ-032 SHALL use one sub-module, priority_select, returning lowest set bit index and valid flag of an NUM_ALLOCATORS-bit vector.
REQ-033 SHALL replace the scheduler-driven writeback_en path in the accelerator top level.

Verification
REQ-034 SHALL test: N=4, offset=0x0100, lanes=4, alloc_done all high same cycle -> writes 0x0100..0x0103 on four consecutive cycles, round_done next cycle, base=4.
REQ-035 SHALL test: lanes=3, done order lane2, lane0, lane1 spaced 3 cycles -> addresses base+2, base+0, base+1 each one cycle after its done; lane3 done ignored, no ack.
REQ-036 SHALL test: base=0xFFFE, offset=0, lanes=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; base becomes 0x0002.
REQ-037 SHALL test: round_start while busy -> overrun=1, round unaffected; clear -> overrun=0, base=0, state IDLE.
REQ-038 SHALL test: rst low after two of four captures -> out_mem_en 0 immediately, no further writes or round_done after release.
REQ-039 SHALL test: alloc_done held high 5 cycles on lane 1 -> single ack, single write.
